// File: rtl/regfile_onehot_wr.sv
// MIPS32 register file with one-hot write select, two combinational read ports,
// write-through bypass and a sticky error flag for malformed (multi-hot) selects.
module regfile_onehot_wr #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREG-1:0]   wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr1,
    input  logic [AW-1:0]     rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              wr_done,
    output logic              sel_err,
    input  logic              clr_err
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_done_q, wr_done_d;
    logic              sel_err_q, sel_err_d;

    logic sel_any;
    logic sel_multi;
    logic sel_valid;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign sel_any   = |wr_sel;
    assign sel_multi = |(wr_sel & (wr_sel - NREG'(1)));
    assign sel_valid = sel_any && !sel_multi;

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (sel_valid && wr_sel[i]) begin
                regs_d[i] = wr_data;
            end
        end
        regs_d[0] = '0;

        wr_done_d = sel_valid && !wr_sel[0];

        sel_err_d = sel_err_q;
        if (sel_multi) begin
            sel_err_d = 1'b1;
        end else if (clr_err) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            wr_done_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            wr_done_q <= wr_done_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Reset gates the bypass too, so reads are 0 while rst_n is low.
    always_comb begin
        rd_data1 = '0;
        if (rst_n && rd_addr1 != '0) begin
            if (sel_valid && wr_sel[rd_addr1]) begin
                rd_data1 = wr_data;
            end else begin
                rd_data1 = regs_q[rd_addr1];
            end
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (rst_n && rd_addr2 != '0) begin
            if (sel_valid && wr_sel[rd_addr2]) begin
                rd_data2 = wr_data;
            end else begin
                rd_data2 = regs_q[rd_addr2];
            end
        end
    end

    assign wr_done = wr_done_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Directed self-checking bench for regfile_onehot_wr.
module tb_regfile_onehot_wr;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        wr_done;
    logic        sel_err;
    logic        clr_err;

    int tests;
    int fails;

    regfile_onehot_wr #(.DATA_W(32), .NREG(32), .AW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wr_done  (wr_done),
        .sel_err  (sel_err),
        .clr_err  (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input int idx, input logic [31:0] data);
        @(negedge clk);
        wr_sel  = 32'h1 << idx;
        wr_data = data;
        @(negedge clk);
        wr_sel  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            check({tag, "_rd1"}, rd_data1, 32'h0);
            check({tag, "_rd2"}, rd_data2, 32'h0);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        clr_err  = 1'b0;
        wr_sel   = 32'h0000_0100;
        wr_data  = 32'hCAFE_F00D;
        rd_addr1 = 5'd8;
        rd_addr2 = 5'd17;

        // 1: reset with a pending valid write (no bypass allowed) then a multi-hot
        #12;
        check("rst_rd1", rd_data1, 32'h0);
        check("rst_rd2", rd_data2, 32'h0);
        check("rst_wr_done", {31'h0, wr_done}, 32'h0);
        wr_sel = 32'h0003_0000;
        @(negedge clk);
        check("rst_sel_err", {31'h0, sel_err}, 32'h0);
        rst_n  = 1'b1;
        wr_sel = '0;
        check_all_zero("post_rst");

        // 2: basic write / read
        @(negedge clk);
        wr_sel  = 32'h0000_0020;
        wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_sel  = '0;
        wr_data = 32'h0BAD_0BAD;
        rd_addr1 = 5'd5;
        #1;
        check("wr5_done", {31'h0, wr_done}, 32'h1);
        check("wr5_rd1", rd_data1, 32'hDEAD_BEEF);
        @(negedge clk);
        check("none_done", {31'h0, wr_done}, 32'h0);
        check("none_keep", rd_data1, 32'hDEAD_BEEF);

        // 3: register 0 stays zero
        wr_sel   = 32'h0000_0001;
        wr_data  = 32'hFFFF_FFFF;
        rd_addr1 = 5'd0;
        #1;
        check("r0_nobypass", rd_data1, 32'h0);
        @(negedge clk);
        wr_sel = '0;
        #1;
        check("r0_done", {31'h0, wr_done}, 32'h0);
        check("r0_rd1", rd_data1, 32'h0);

        // 4: bypass on both ports
        @(negedge clk);
        wr_sel   = 32'h8000_0000;
        wr_data  = 32'h1234_5678;
        rd_addr1 = 5'd31;
        rd_addr2 = 5'd31;
        #1;
        check("byp_rd2", rd_data2, 32'h1234_5678);
        check("byp_rd1", rd_data1, 32'h1234_5678);
        @(negedge clk);
        wr_sel  = '0;
        wr_data = 32'h0;
        #1;
        check("byp_done", {31'h0, wr_done}, 32'h1);
        check("byp_stored", rd_data2, 32'h1234_5678);

        // 5: multi-hot rejected, sticky error, clear, set-wins
        write_reg(3, 32'hA5A5_A5A5);
        wr_sel   = 32'h0000_0018;
        wr_data  = 32'h0000_0001;
        rd_addr1 = 5'd3;
        rd_addr2 = 5'd4;
        #1;
        check("multi_nobyp3", rd_data1, 32'hA5A5_A5A5);
        check("multi_nobyp4", rd_data2, 32'h0);
        @(negedge clk);
        wr_sel = '0;
        #1;
        check("multi_err", {31'h0, sel_err}, 32'h1);
        check("multi_done", {31'h0, wr_done}, 32'h0);
        check("multi_r3", rd_data1, 32'hA5A5_A5A5);
        check("multi_r4", rd_data2, 32'h0);
        @(negedge clk);
        check("err_sticky", {31'h0, sel_err}, 32'h1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clr", {31'h0, sel_err}, 32'h0);
        clr_err = 1'b1;
        wr_sel  = 32'h0000_0018;
        @(negedge clk);
        clr_err = 1'b0;
        wr_sel  = '0;
        check("err_setwins", {31'h0, sel_err}, 32'h1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("err_clr2", {31'h0, sel_err}, 32'h0);

        // 6: fill, then async reset between edges
        for (int i = 1; i < 32; i++) begin
            write_reg(i, 32'(i));
        end
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd30;
        #1;
        check("fill_r7", rd_data1, 32'd7);
        check("fill_r30", rd_data2, 32'd30);
        @(negedge clk);
        wr_sel   = 32'h1 << 9;
        wr_data  = 32'h0000_0099;
        rd_addr1 = 5'd9;
        @(posedge clk);
        #1;
        check("mid_done", {31'h0, wr_done}, 32'h1);
        check("mid_byp_new", rd_data1, 32'h0000_0099);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rd1", rd_data1, 32'h0);
        check("arst_rd2", rd_data2, 32'h0);
        check("arst_done", {31'h0, wr_done}, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        wr_sel = '0;
        check_all_zero("post_arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
